// File: rtl/lift_seq_ctrl.sv
// lift_seq_ctrl: frame sequencer for the sample ROM and the lifting datapath.
// Issues ROM addresses for one frame, drives the datapath enable, tracks each
// sample through the datapath with a valid/last/odd shift register, honours
// downstream HOLD and counts completed frames.
module lift_seq_ctrl #(
    parameter int AW       = 4,
    parameter int PIPE_LAT = 5,
    parameter int FCW      = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           START,
    input  logic [AW-1:0]  LEN,
    input  logic           HOLD,
    output logic [AW-1:0]  ADD,
    output logic           ODD,
    output logic           EN,
    output logic           OUT_VALID,
    output logic           OUT_LAST,
    output logic           OUT_ODD,
    output logic           BUSY,
    output logic           DONE,
    output logic [FCW-1:0] FRAME_CNT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [AW-1:0]       add_q;
    logic [AW:0]         cnt_q;
    logic [AW:0]         len_q;
    logic [PIPE_LAT-1:0] vld_p;
    logic [PIPE_LAT-1:0] last_p;
    logic [PIPE_LAT-1:0] odd_p;
    logic [FCW-1:0]      fcnt_q;
    logic                issue;
    logic                shift;
    logic                last_issue;
    logic                tail_out;

    // Length compare is one bit wider than the address so a zero LEN (2^AW) fits.
    assign last_issue = (cnt_q == (len_q - 1'b1));
    assign tail_out   = vld_p[PIPE_LAT-1] & ~HOLD;

    assign ADD       = add_q;
    assign ODD       = add_q[0];
    assign OUT_VALID = tail_out;
    assign OUT_LAST  = tail_out & last_p[PIPE_LAT-1];
    assign OUT_ODD   = tail_out & odd_p[PIPE_LAT-1];
    assign FRAME_CNT = fcnt_q;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus enable/busy/done and the issue/shift strobes.
    always_comb begin
        state_d = state_q;
        EN      = 1'b0;
        BUSY    = 1'b0;
        DONE    = 1'b0;
        issue   = 1'b0;
        shift   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                BUSY  = 1'b1;
                EN    = ~HOLD;
                issue = ~HOLD;
                shift = ~HOLD;
                if (issue && last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                BUSY  = 1'b1;
                EN    = ~HOLD;
                shift = ~HOLD;
                if (tail_out && last_p[PIPE_LAT-1]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address, issue count and latched frame length.
    always_ff @(posedge CLK) begin
        if (RST) begin
            add_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
        end else if (state_q == S_IDLE && START) begin
            add_q <= '0;
            cnt_q <= '0;
            len_q <= (LEN == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, LEN};
        end else if (issue) begin
            add_q <= add_q + 1'b1;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Sample tracker: a new entry per enabled cycle, bubbles while draining.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p  <= '0;
            last_p <= '0;
            odd_p  <= '0;
        end else if (shift) begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                vld_p[i]  <= vld_p[i-1];
                last_p[i] <= last_p[i-1];
                odd_p[i]  <= odd_p[i-1];
            end
            vld_p[0]  <= issue;
            last_p[0] <= issue & last_issue;
            odd_p[0]  <= issue & add_q[0];
        end
    end

    // Completed-frame counter, bumped as DONE is left.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fcnt_q <= '0;
        end else if (state_q == S_DONE) begin
            fcnt_q <= fcnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_lift_seq_ctrl.sv
// Testbench for lift_seq_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_lift_seq_ctrl;

    localparam int PL = 5;

    logic       CLK = 1'b0;
    logic       RST, START, HOLD;
    logic [3:0] LEN;
    logic [3:0] ADD;
    logic       ODD, EN, OUT_VALID, OUT_LAST, OUT_ODD, BUSY, DONE;
    logic [7:0] FRAME_CNT;
    logic [3:0] add2;
    logic       odd2, en2, ov2, ol2, oo2, busy2, done2;
    logic [1:0] fc2;

    int n_tests = 0;
    int n_fail  = 0;

    lift_seq_ctrl #(.AW(4), .PIPE_LAT(PL), .FCW(8)) dut (
        .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .HOLD(HOLD),
        .ADD(ADD), .ODD(ODD), .EN(EN), .OUT_VALID(OUT_VALID),
        .OUT_LAST(OUT_LAST), .OUT_ODD(OUT_ODD), .BUSY(BUSY), .DONE(DONE),
        .FRAME_CNT(FRAME_CNT)
    );

    lift_seq_ctrl #(.AW(4), .PIPE_LAT(PL), .FCW(2)) dut2 (
        .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .HOLD(HOLD),
        .ADD(add2), .ODD(odd2), .EN(en2), .OUT_VALID(ov2),
        .OUT_LAST(ol2), .OUT_ODD(oo2), .BUSY(busy2), .DONE(done2),
        .FRAME_CNT(fc2)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic       rst, st, hold;
        logic [3:0] len;
        logic [3:0] add;
        logic       en, ov, ol, oo, busy, done;
        int         fc;
    } vec_t;

    vec_t tbl[$];

    // model state
    int m_mode, m_len, m_iss, m_add, m_cnt;
    int q_age[$];
    bit q_last[$];
    bit q_odd[$];

    function automatic logic [10:0] pack(logic [3:0] a, logic o, logic e, logic v,
                                         logic l, logic d, logic b, logic dn);
        return {a, o, e, v, l, d, b, dn};
    endfunction

    task automatic nxt;
        @(posedge CLK);
        #1;
    endtask

    task automatic smp;
        @(negedge CLK);
    endtask

    task automatic chk_vec(input string nm, input logic [10:0] exp);
        logic [10:0] got;
        got = pack(ADD, ODD, EN, OUT_VALID, OUT_LAST, OUT_ODD, BUSY, DONE);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: {add,odd,en,ov,last,oodd,busy,done} got %b required %b",
                     nm, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    task automatic row(input logic rst, input logic st, input logic hold,
                       input logic [3:0] len, input logic [3:0] add,
                       input logic en, input logic ov, input logic ol, input logic oo,
                       input logic busy, input logic done, input int fc);
        vec_t v;
        v.rst = rst; v.st = st; v.hold = hold; v.len = len; v.add = add;
        v.en = en; v.ov = ov; v.ol = ol; v.oo = oo; v.busy = busy; v.done = done;
        v.fc = fc;
        tbl.push_back(v);
    endtask

    initial begin
        int         done_cnt;
        int         seen;
        int         k;
        bit         hd, ev, fin;
        logic [3:0] ea;
        logic       e_en, e_ov, e_ol, e_oo, e_dn;

        // LEN=3 frame; LEN changed to 7 mid-frame
        row(0,1,0,3, 0, 0,0,0,0,0,0, 0);
        row(0,0,0,3, 0, 1,0,0,0,1,0, 0);
        row(0,0,0,7, 1, 1,0,0,0,1,0, 0);
        row(0,0,0,7, 2, 1,0,0,0,1,0, 0);
        row(0,0,0,7, 3, 1,0,0,0,1,0, 0);
        row(0,0,0,7, 3, 1,0,0,0,1,0, 0);
        row(0,0,0,7, 3, 1,1,0,0,1,0, 0);
        row(0,0,0,7, 3, 1,1,0,1,1,0, 0);
        row(0,0,0,7, 3, 1,1,1,0,1,0, 0);
        row(0,0,0,7, 3, 0,0,0,0,0,1, 0);
        row(0,0,0,7, 3, 0,0,0,0,0,0, 1);
        row(1,0,0,0, 3, 0,0,0,0,0,0, 1);
        // LEN=4 with HOLD in cycles 0 (idle), 2-3 and 7
        row(0,1,1,4, 0, 0,0,0,0,0,0, 0);
        row(0,0,0,4, 0, 1,0,0,0,1,0, 0);
        row(0,0,1,4, 1, 0,0,0,0,1,0, 0);
        row(0,0,1,4, 1, 0,0,0,0,1,0, 0);
        row(0,0,0,4, 1, 1,0,0,0,1,0, 0);
        row(0,0,0,4, 2, 1,0,0,0,1,0, 0);
        row(0,0,0,4, 3, 1,0,0,0,1,0, 0);
        row(0,0,1,4, 4, 0,0,0,0,1,0, 0);
        row(0,0,0,4, 4, 1,0,0,0,1,0, 0);
        row(0,0,0,4, 4, 1,1,0,0,1,0, 0);
        row(0,0,0,4, 4, 1,1,0,1,1,0, 0);
        row(0,0,0,4, 4, 1,1,0,0,1,0, 0);
        row(0,0,0,4, 4, 1,1,1,1,1,0, 0);
        row(0,0,0,4, 4, 0,0,0,0,0,1, 0);
        row(0,0,0,4, 4, 0,0,0,0,0,0, 1);

        RST = 1'b1; START = 1'b0; HOLD = 1'b0; LEN = 4'd0;
        nxt;
        nxt;
        RST = 1'b0;
        smp;
        chk_vec("reset_state", 11'd0);
        chk_int("reset_fc", int'(FRAME_CNT), 0);
        chk_int("reset_fc2", int'(fc2), 0);

        foreach (tbl[i]) begin
            nxt;
            RST = tbl[i].rst; START = tbl[i].st; HOLD = tbl[i].hold; LEN = tbl[i].len;
            smp;
            chk_vec($sformatf("tbl%0d", i),
                    pack(tbl[i].add, tbl[i].add[0], tbl[i].en, tbl[i].ov, tbl[i].ol,
                         tbl[i].oo, tbl[i].busy, tbl[i].done));
            chk_int($sformatf("tbl%0d_fc", i), int'(FRAME_CNT), tbl[i].fc);
        end

        // Full 16-sample frame with ignored START pulses in cycles 3 and 10
        nxt;
        RST = 1'b1; START = 1'b0; HOLD = 1'b0;
        nxt;
        RST = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            if (c > 0) nxt;
            START = (c == 0 || c == 3 || c == 10);
            LEN   = (c == 0) ? 4'd0 : 4'(c);
            smp;
            ea   = (c >= 1 && c <= 16) ? 4'(c - 1) : 4'd0;
            e_en = (c >= 1 && c <= 21);
            e_ov = (c >= 6 && c <= 21);
            e_oo = e_ov && ((c - 6) % 2 == 1);
            e_ol = (c == 21);
            e_dn = (c == 22);
            chk_vec($sformatf("full_c%0d", c), pack(ea, ea[0], e_en, e_ov, e_ol, e_oo, e_en, e_dn));
            chk_int($sformatf("full_fc_c%0d", c), int'(FRAME_CNT), (c >= 23) ? 1 : 0);
            done_cnt += int'(DONE);
        end
        chk_int("full_done_count", done_cnt, 1);

        // Reset in cycle 8 of a 16-sample frame
        for (int c = 0; c <= 8; c++) begin
            nxt;
            START = (c == 0);
            LEN   = 4'd0;
            RST   = (c == 8);
        end
        nxt;
        RST = 1'b0;
        smp;
        chk_vec("rst_mid_outputs", 11'd0);
        chk_int("rst_mid_fc", int'(FRAME_CNT), 0);
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            nxt;
            smp;
            seen += int'(DONE) + int'(BUSY);
        end
        chk_int("rst_mid_no_done", seen, 0);

        // Back-to-back LEN=1 frames: 2-bit counter wraps 1,2,3,0
        nxt;
        RST = 1'b1;
        nxt;
        RST = 1'b0; START = 1'b1; LEN = 4'd1;
        for (int f = 0; f < 4; f++) begin
            smp;
            k = 0;
            while (DONE !== 1'b1 && k < 20) begin
                nxt;
                smp;
                k++;
            end
            chk_int($sformatf("wrap_done_f%0d", f), int'(DONE), 1);
            nxt;
            smp;
            chk_int($sformatf("wrap_fc2_f%0d", f), int'(fc2), (f + 1) % 4);
            chk_int($sformatf("wrap_fc_f%0d", f), int'(FRAME_CNT), f + 1);
        end
        START = 1'b0;

        // Randomized traffic against the reference model
        nxt;
        RST = 1'b1;
        nxt;
        RST = 1'b0; START = 1'b0; HOLD = 1'b0;
        m_mode = 0; m_len = 0; m_iss = 0; m_add = 0; m_cnt = 0;
        q_age.delete(); q_last.delete(); q_odd.delete();
        for (int n = 0; n < 3000; n++) begin
            if (n > 0) nxt;
            RST   = ($urandom_range(0, 199) == 0);
            START = ($urandom_range(0, 5) == 0);
            LEN   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(1, 4));
            HOLD  = ($urandom_range(0, 3) == 0);
            smp;
            hd   = (m_mode == 1) && (q_age.size() > 0) && (q_age[0] == PL);
            ev   = hd && !HOLD;
            ea   = 4'(m_add % 16);
            e_en = (m_mode == 1) && !HOLD;
            e_ol = ev && q_last[0];
            e_oo = ev && q_odd[0];
            chk_vec($sformatf("rand%0d", n),
                    pack(ea, ea[0], e_en, ev, e_ol, e_oo, (m_mode == 1), (m_mode == 2)));
            chk_int($sformatf("rand%0d_fc", n), int'(FRAME_CNT), m_cnt % 256);
            chk_int($sformatf("rand%0d_fc2", n), int'(fc2), m_cnt % 4);

            if (RST) begin
                m_mode = 0; m_len = 0; m_iss = 0; m_add = 0; m_cnt = 0;
                q_age.delete(); q_last.delete(); q_odd.delete();
            end else begin
                case (m_mode)
                    0: begin
                        if (START) begin
                            m_mode = 1;
                            m_len  = (LEN == 4'd0) ? 16 : int'(LEN);
                            m_iss  = 0;
                            m_add  = 0;
                        end
                    end
                    1: begin
                        if (!HOLD) begin
                            fin = 1'b0;
                            if (ev) begin
                                fin = q_last[0];
                                void'(q_age.pop_front());
                                void'(q_last.pop_front());
                                void'(q_odd.pop_front());
                            end
                            foreach (q_age[i]) q_age[i]++;
                            if (m_iss < m_len) begin
                                q_age.push_back(1);
                                q_last.push_back(m_iss == m_len - 1);
                                q_odd.push_back(1'(m_add & 1));
                                m_iss++;
                                m_add = (m_add + 1) % 16;
                            end
                            if (fin) m_mode = 2;
                        end
                    end
                    default: begin
                        m_mode = 0;
                        m_cnt++;
                    end
                endcase
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lift_seq_ctrl.md
# lift_seq_ctrl

Frame sequencer for the 16-entry sample ROM and lifting (predict/update) datapath. After a START pulse it issues a programmable number of ROM addresses and drives the datapath clock enable. It tracks every sample through the datapath pipeline with a valid/last/odd shift register, honours downstream HOLD back-pressure, and reports frame completion. It sits between the system control logic and the datapath's address/enable inputs.

## Interface
- AW, 4, sample address width; frame holds at most 2^AW samples
- PIPE_LAT, 5, datapath latency in enabled cycles from address issue to result; legal range 1..8
- FCW, 8, width of the completed-frame counter

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- START  in  1  frame request; accepted only in IDLE
- LEN  in  AW  frame length, sampled when START is accepted; 0 means 2^AW
- HOLD  in  1  downstream stall; freezes the address, the pipeline tracker and EN
- ADD  out  AW  ROM sample address (registered)
- ODD  out  1  ADD[0]; selects the halving/predict path for the current address
- EN  out  1  datapath enable = (FETCH or DRAIN) and !HOLD
- OUT_VALID  out  1  the datapath result is valid this cycle = tracker tail and !HOLD
- OUT_LAST  out  1  tail sample is the last of the frame; qualified by OUT_VALID
- OUT_ODD  out  1  tail sample came from an odd address; qualified by OUT_VALID
- BUSY  out  1  high in FETCH and DRAIN
- DONE  out  1  one-cycle pulse in the DONE state
- FRAME_CNT  out  FCW  number of completed frames, wraps modulo 2^FCW

## Operation
- States are IDLE, FETCH, DRAIN and DONE. Reset state is IDLE.
- Reset values:
  - ADD=0, tracker cleared, FRAME_CNT=0, internal issue count=0, latched length=0.
  - All 1-bit outputs are 0.
- IDLE:
  - START=1 latches LEN, sets ADD=0 and issue count=0, then goes to FETCH.
  - HOLD has no effect on START acceptance.
- FETCH: a cycle with HOLD=0 is an issue cycle.
  - The tracker shifts in {valid=1, last=(count==len-1), odd=ADD[0]}.
  - ADD and the issue count each increment by 1. ADD wraps modulo 2^AW, so a full 16-sample frame leaves ADD=0.
  - The issue flagged last moves the block to DRAIN.
  - A HOLD=1 cycle changes nothing.
- DRAIN:
  - Each cycle with HOLD=0 shifts the tracker and inserts a bubble (valid=0).
  - When OUT_VALID and OUT_LAST are both 1, the block goes to DONE.
- DONE:
  - Lasts exactly one cycle with DONE=1 and BUSY=0.
  - FRAME_CNT increments on the exiting edge, then the block returns to IDLE.
- START is ignored in FETCH, DRAIN and DONE. It is not queued.
- LEN changes after acceptance are ignored.
- Tracker: PIPE_LAT entries of {valid, last, odd}. It shifts only when HOLD=0 and the state is FETCH or DRAIN.
- The length comparison is done at AW+1 bits, so len=2^AW issues addresses 0..2^AW-1.

## Timing
- START is accepted at cycle s. The first issue cycle is s+1.
- With no HOLD:
  - addresses 0..L-1 are presented in cycles s+1..s+L;
  - the sample issued in cycle c appears with OUT_VALID=1 in cycle c+PIPE_LAT;
  - DONE=1 in cycle s+L+PIPE_LAT+1;
  - the next START is accepted no earlier than s+L+PIPE_LAT+2.
- Each HOLD=1 cycle during FETCH or DRAIN delays all later events by exactly one cycle.
- While HOLD=1, EN and OUT_VALID are 0. ADD, ODD and the tracker contents do not change.
- HOLD asserted in the intended last issue cycle means no issue. The block stays in FETCH.
- RST=1 in any state clears everything on that edge, FRAME_CNT included, and returns to IDLE. No DONE pulse is produced.
- RST and START in the same cycle: reset wins.
- FRAME_CNT wraps from 2^FCW-1 to 0.

## Test plan
- LEN=0, PIPE_LAT=5, START at cycle 0, no HOLD -> ADD=0..15 in cycles 1..16; EN=1 in cycles 1..21; OUT_VALID=1 in cycles 6..21 with OUT_ODD alternating 0,1; OUT_LAST=1 only in cycle 21; DONE=1 in cycle 22; FRAME_CNT=1; ADD=0 afterwards.
- LEN=3 -> ADD=0,1,2 in cycles 1..3; OUT_VALID=1 in cycles 6..8; DONE=1 in cycle 9; LEN changed to 7 at cycle 2 has no effect.
- LEN=4, HOLD high in cycles 2-3 and again in cycle 7 -> ADD holds at 1 during cycles 2-3; EN=0 and OUT_VALID=0 in all HOLD cycles; DONE=1 in cycle 13 (10+3).
- START pulsed in cycles 3 and 10 of an active frame -> both ignored; exactly one DONE; BUSY stays 1 until DONE.
- RST=1 in cycle 8 of a LEN=0 frame -> in cycle 9 the block is IDLE, ADD=0, all flags 0, FRAME_CNT=0, and no DONE pulse appears.
- FCW=2, four back-to-back LEN=1 frames -> FRAME_CNT steps 1,2,3,0.
